// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// result-flag bit positions and small decode helpers.
package alu_pkg;

    localparam int WIDTH_FIXED = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1101;
    localparam logic [3:0] OP_ILL_E = 4'b1110;
    localparam logic [3:0] OP_ILL_F = 4'b1111;

    localparam int FLG_C = 3;
    localparam int FLG_N = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic is_illegal(input logic [3:0] sel);
        return (sel == OP_ILL_E) || (sel == OP_ILL_F);
    endfunction

    // Illegal codes skip execution entirely and present an error result at once.
    function automatic state_t dispatch(input logic [3:0] sel);
        if (sel == OP_MUL)
            return MUL;
        else if (is_illegal(sel))
            return HOLD;
        else
            return EXEC;
    endfunction

    function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                              input logic z, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier. The first iteration runs on the
// start edge, so the final product is ready MUL_CYCLES-1 edges later.
module mul_shift_add #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0] mcand;
    logic [5:0]       count;
    logic             busy;

    // One step: conditionally add the multiplicand into the upper half, then
    // shift the whole register right, keeping the add carry as the new MSB.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    // NOTE: synchronous reset lives inside the clocked block; every register
    // here is plain state (no memory arrays), so all of it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= a;
                product <= step({{WIDTH{1'b0}}, b}, a);
                count   <= 6'd1;
                busy    <= 1'b1;
            end else if (busy) begin
                product <= step(product, mcand);
                if (count == 6'(MUL_CYCLES - 1)) begin
                    busy  <= 1'b0;
                    count <= '0;
                    done  <= 1'b1;
                end else begin
                    count <= count + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer around an external combinational 32-bit ALU: registers
// commands onto the ALU pins, captures results, and runs MUL iteratively.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_ovf,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic [3:0]       res_flags,
    output logic             res_err
);

    state_t             state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // A held result frees the command port only on the edge it is consumed.
    assign cmd_ready = (state == IDLE) || ((state == HOLD) && res_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign mul_start = accept && (cmd_sel == OP_MUL);

    mul_shift_add #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (cmd_a),
        .b       (cmd_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            alu_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_flags <= '0;
            res_err   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_sel;
                alu_cin <= cmd_cin;
            end

            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        state <= dispatch(cmd_sel);
                        if (is_illegal(cmd_sel)) begin
                            res_valid <= 1'b1;
                            res_y     <= '0;
                            res_flags <= '0;
                            res_err   <= 1'b1;
                        end else begin
                            res_valid <= 1'b0;
                        end
                    end else if ((state == HOLD) && res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end

                EXEC: begin
                    res_y     <= alu_y;
                    res_flags <= pack_flags(alu_cout, alu_neg, alu_zero, alu_ovf);
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end

                MUL: begin
                    if (mul_done) begin
                        res_y     <= mul_product[WIDTH-1:0];
                        res_flags <= pack_flags(|mul_product[2*WIDTH-1:WIDTH], 1'b0,
                                                mul_product[WIDTH-1:0] == '0, 1'b0);
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stand-in and a
// result scoreboard checked whenever a result is handed off.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_cin;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_sel;
    logic        alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_y;
    logic [3:0]  res_flags;

    int   n_tests = 0;
    int   n_fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_cin   (cmd_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_cin   (alu_cin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_flags (res_flags),
        .res_err   (res_err)
    );

    // Behavioural stand-in for the external ALU (only the ops exercised here).
    always_comb begin
        alu_y    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_sel)
            OP_AND: alu_y = alu_a & alu_b;
            OP_ADD: begin
                {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            default: alu_y = alu_a | alu_b;
        endcase
        alu_neg  = alu_y[31];
        alu_zero = (alu_y == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each result handed off (valid && ready) must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_y", res_y, e.y);
                check("sb_flags", res_flags, e.flags);
                check("sb_err", res_err, e.err);
            end
        end
    end

    function automatic exp_t mul_exp(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t        e;
        p       = {32'd0, a} * {32'd0, b};
        e.y     = p[31:0];
        e.flags = {|p[63:32], 1'b0, p[31:0] == 32'd0, 1'b0};
        e.err   = 1'b0;
        return e;
    endfunction

    // Offer a command and return 1ns after the edge that accepted it.
    task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
        int budget;
        budget    = 0;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        @(negedge clk);
        while (!cmd_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Count edges after the accept edge until res_valid rises (bounded).
    task automatic wait_result(input string tag, input int exp_cycles);
        int cycles;
        cycles = 0;
        while (!res_valid && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, exp_cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
        res_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_res_y", res_y, 0);
        rst = 1'b0;

        // ADD with signed overflow
        res_ready = 1'b1;
        sb.push_back('{y: 32'h8000_0000, flags: 4'b0101, err: 1'b0});
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check("add_alu_sel", alu_sel, OP_ADD);
        check("add_valid_early", res_valid, 0);
        wait_result("add", 1);
        check("add_y", res_y, 32'h8000_0000);
        check("add_flags", res_flags, 4'b0101);
        @(posedge clk);
        #1;
        check("add_pulse", res_valid, 0);

        // Two ANDs under backpressure
        res_ready = 1'b0;
        sb.push_back('{y: 32'h00F0_00F0, flags: 4'b0000, err: 1'b0});
        send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        sb.push_back('{y: 32'h1234_0000, flags: 4'b0000, err: 1'b0});
        cmd_valid = 1'b1;
        cmd_sel   = OP_AND;
        cmd_a     = 32'hFFFF_0000;
        cmd_b     = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("bp_valid", res_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_y", res_y, 32'h00F0_00F0);
            check("bp_res_flags", res_flags, 4'b0000);
            check("bp_alu_a", alu_a, 32'hF0F0_F0F0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("b2b_alu_b", alu_b, 32'h1234_5678);
        check("b2b_valid_drop", res_valid, 0);
        wait_result("and2", 1);
        check("and2_y", res_y, 32'h1234_0000);

        // Multiply: 2^16 * 2^16 overflows into the upper half
        sb.push_back(mul_exp(32'h0001_0000, 32'h0001_0000));
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_result("mul1", 32);
        check("mul1_y", res_y, 32'd0);
        check("mul1_flags", res_flags, 4'b1010);

        sb.push_back(mul_exp(32'd3, 32'd5));
        send(OP_MUL, 32'd3, 32'd5, 1'b0);
        wait_result("mul2", 32);
        check("mul2_y", res_y, 32'd15);
        check("mul2_flags", res_flags, 4'b0000);

        // Illegal opcodes present immediately
        sb.push_back('{y: 32'd0, flags: 4'b0000, err: 1'b1});
        send(OP_ILL_F, 32'hDEAD_BEEF, 32'h1, 1'b1);
        wait_result("ill_f", 0);
        check("ill_f_err", res_err, 1);
        check("ill_f_y", res_y, 32'd0);
        check("ill_f_flags", res_flags, 4'b0000);

        sb.push_back('{y: 32'd0, flags: 4'b0000, err: 1'b1});
        send(OP_ILL_E, 32'h5, 32'h6, 1'b0);
        wait_result("ill_e", 0);
        check("ill_e_err", res_err, 1);

        // Reset in the middle of a multiply abandons it
        send(OP_MUL, 32'd7, 32'd9, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_res_valid", res_valid, 0);
        check("mrst_cmd_ready", cmd_ready, 1);
        check("mrst_alu_a", alu_a, 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid) seen = 1;
        end
        check("mrst_no_result", seen, 0);

        sb.push_back('{y: 32'd5, flags: 4'b0000, err: 1'b0});
        send(OP_ADD, 32'd2, 32'd3, 1'b0);
        wait_result("add23", 1);
        check("add23_y", res_y, 32'd5);

        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer wrapped around the combinational 32-bit ALU. It accepts ALU commands (op select, operands, carry-in) over a valid/ready handshake and registers them onto the ALU input pins. It captures the ALU result and flags into an output register presented over a second valid/ready handshake. It also runs the unsigned multiply opcode (4'b1001), which the ALU does not implement, as an iterative 32-cycle shift-add.

## Interface
Parameters:
- WIDTH, 32, operand/result width; fixed at 32, the only supported value
- MUL_CYCLES, 32, multiply iterations; equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_sel  in  4  ALU op code
- cmd_a, cmd_b  in  32  operands
- cmd_cin  in  1  carry-in
- alu_a, alu_b  out  32  registered operands to ALU A/B
- alu_sel  out  4  registered op to ALU sel
- alu_cin  out  1  registered carry-in to ALU Cin
- alu_y  in  32  ALU Y
- alu_cout, alu_neg, alu_zero, alu_ovf  in  1 each  ALU flags
- res_valid  out  1  result held
- res_ready  in  1  consumer takes result
- res_y  out  32  result
- res_flags  out  4  {Cout, Negative, Zero, Overflow}
- res_err  out  1  illegal opcode

## Operation
- States: IDLE, EXEC, MUL, HOLD.
- IDLE: cmd_ready=1. On accept, latch sel/a/b/cin into alu_* registers.
  - sel=4'b1001 -> MUL.
  - sel in {1110, 1111} -> HOLD directly with res_y=0, res_flags=0, res_err=1.
  - All other codes -> EXEC.
- EXEC: one cycle. At its closing edge, capture alu_y and the flags into res_* with res_err=0, then go to HOLD.
- MUL: shift-add on alu_a × alu_b. Uses a 64-bit product register and a 6-bit iteration counter counting 0..31. Each cycle: if multiplier bit is 1, add the multiplicand to the upper half, then shift right one bit.
  - After the 32nd iteration: res_y = product[31:0].
  - Cout = |product[63:32].
  - Zero = (res_y == 0).
  - Negative = 0, Overflow = 0.
  - Then go to HOLD.
- HOLD: res_valid=1. res_* stay stable until res_ready.
  - cmd_ready = res_ready in HOLD, so a back-to-back accept is allowed on the same edge the result is taken. The new command's sel decides the next state, as in IDLE.
  - res_ready without cmd_valid -> IDLE.
- alu_* hold the last accepted command until the next accept. They do not change in EXEC, MUL or HOLD.
- During MUL the ALU outputs are ignored.

## Timing
- Reset values: state=IDLE, cmd_ready=1 (combinational from state), res_valid=0, res_y=0, res_flags=0, res_err=0, alu_a=0, alu_b=0, alu_sel=0, alu_cin=0, product=0, counter=0.
- Non-multiply latency:
  - accept at edge N, EXEC during cycle N→N+1, capture at edge N+1.
  - res_valid=1 from edge N+1.
  - Minimum throughput: 1 result per 2 cycles.
- Multiply latency: accept at edge N, res_valid=1 from edge N+32.
- Illegal opcode: res_valid=1 from edge N (no EXEC cycle).
- cmd_ready is combinational from state and res_ready. There is no combinational path from cmd_valid to cmd_ready.
- res_valid must never drop without res_ready. res_y, res_flags and res_err must not change while res_valid && !res_ready.
- Reset mid-operation (EXEC, MUL or HOLD): abandon the operation on that edge, return to reset values, and emit no result.
- rst has priority over any handshake on the same edge.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams OP_AND=4'b0000 … OP_ADD=4'b0110, OP_SUB=4'b0111, OP_MUL=4'b1001, OP_ASR=4'b1101
  - state encoding (IDLE=2'd0, EXEC=2'd1, MUL=2'd2, HOLD=2'd3)
  - flag bit indices FLG_C=3, FLG_N=2, FLG_Z=1, FLG_V=0
- One sub-module, `mul_shift_add`. It holds the product register and counter, with ports clk, rst, start, a, b, done, product[63:0]. `done` pulses for one cycle on completion.
- The sequencer FSM and result registers sit in `alu_cmd_sequencer`. The ALU stays external and is connected at the next level up.

## Test plan
- Reset: hold rst 2 cycles -> res_valid=0, cmd_ready=1, alu_sel=0, res_y=0.
- ADD: sel=0110, a=32'h7FFFFFFF, b=1, cin=0, res_ready=1, with the ALU connected -> 2 cycles later res_valid=1, res_y=32'h80000000, flags N=1, V=1, Z=0, C=0. One-cycle valid pulse.
- Back-to-back with backpressure: two AND commands, res_ready=0 for 5 cycles -> res_* stable and cmd_ready=0 throughout. Raise res_ready -> second command accepted on the same edge, its result 2 cycles later.
- MUL: a=32'h00010000, b=32'h00010000 -> after 32 cycles res_y=0, Zero=1, Cout=1. Then a=3, b=5 -> res_y=15, Cout=0, Zero=0.
- Illegal opcode sel=1111 -> res_valid next edge, res_err=1, res_y=0, res_flags=0.
- Reset at MUL iteration 10 -> no res_valid afterwards, state IDLE. A following ADD 2+3 gives res_y=5.
